// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared register map, bit positions and bus FSM type for the uart rx fifo
package uart_rx_fifo_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int THR_W  = 9;

  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_DATA      = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_THRESHOLD = 5'h0C;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_FLUSH_BIT     = 1;
  localparam int STATUS_EMPTY_BIT   = 0;
  localparam int STATUS_FULL_BIT    = 1;
  localparam int STATUS_OVERRUN_BIT = 2;
  localparam int STATUS_LEVEL_LSB   = 8;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_HOLD
  } bus_state_e;

  function automatic logic [DATA_W-1:0] status_word(input logic empty, input logic full,
                                                    input logic overrun,
                                                    input logic [THR_W-1:0] level);
    logic [DATA_W-1:0] w;
    w = '0;
    w[STATUS_EMPTY_BIT] = empty;
    w[STATUS_FULL_BIT] = full;
    w[STATUS_OVERRUN_BIT] = overrun;
    w[STATUS_LEVEL_LSB +: THR_W] = level;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - register bus between a master and the uart rx fifo
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic              select;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_i;
  logic              ready;
  logic [DATA_W-1:0] data_o;

  modport master (output select, wstrb, addr, data_i, input ready, data_o);
  modport slave  (input select, wstrb, addr, data_i, output ready, data_o);

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - single-clock fifo with flush and simultaneous push/pop when full
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // A pop frees the slot in the same edge, so a full fifo still accepts a concurrent push.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - uart receive fifo with register bus, status flags and threshold interrupt
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int THR_RESET = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_fifo_if.slave bus,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          irq
);
  localparam int LW = $clog2(DEPTH) + 1;

  bus_state_e        state_q, state_d;
  logic              ready;
  logic              rd_acc, wr_acc;
  logic              hit_ctrl, hit_status, hit_data, hit_thr;
  logic              enable, overrun;
  logic              flush, push, pop, overrun_set, overrun_clr;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic [THR_W-1:0]  level9, threshold;
  logic [7:0]        head;
  logic [DATA_W-1:0] rdata;
  logic              unused_bits;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  // IDLE is the armed state; HOLD waits for select to drop so a held request is served once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (bus.select) state_d = BUS_ACK;
      BUS_ACK:  state_d = bus.select ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD: if (!bus.select) state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == BUS_ACK);
  end

  assign wr_acc     = ready & (bus.wstrb != 4'b0000);
  assign rd_acc     = ready & (bus.wstrb == 4'b0000);
  assign hit_ctrl   = (bus.addr == ADDR_CTRL);
  assign hit_status = (bus.addr == ADDR_STATUS);
  assign hit_data   = (bus.addr == ADDR_DATA);
  assign hit_thr    = (bus.addr == ADDR_THRESHOLD);

  assign flush       = wr_acc & hit_ctrl & bus.wstrb[0] & bus.data_i[CTRL_FLUSH_BIT];
  assign pop         = rd_acc & hit_data;
  assign push        = enable & rx_valid;
  assign overrun_set = push & fifo_full & ~(pop & ~fifo_empty) & ~flush;
  assign overrun_clr = wr_acc & hit_status & bus.wstrb[0] & bus.data_i[STATUS_OVERRUN_BIT];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .head    (head)
  );

  assign level9 = THR_W'(fifo_level);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      overrun   <= 1'b0;
      threshold <= THR_W'(THR_RESET);
      irq       <= 1'b0;
    end else begin
      if (wr_acc && hit_ctrl && bus.wstrb[0]) enable <= bus.data_i[CTRL_ENABLE_BIT];
      if (wr_acc && hit_thr) begin
        if (bus.wstrb[0]) threshold[7:0] <= bus.data_i[7:0];
        if (bus.wstrb[1]) threshold[8]   <= bus.data_i[8];
      end
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      irq <= enable & (threshold != '0) & (level9 >= threshold);
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      ADDR_CTRL:      rdata[CTRL_ENABLE_BIT] = enable;
      ADDR_STATUS:    rdata = status_word(fifo_empty, fifo_full, overrun, level9);
      ADDR_DATA:      rdata[7:0] = fifo_empty ? 8'h00 : head;
      ADDR_THRESHOLD: rdata[THR_W-1:0] = threshold;
      default:        rdata = '0;
    endcase
  end

  assign bus.ready  = ready;
  assign bus.data_o = ready ? rdata : '0;

  assign unused_bits = ^{bus.data_i[31:9], bus.wstrb[3:2]};

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter THR_RESET, default 1, meaning the reset value of THRESHOLD.
REQ-003 SHALL have ports `clk  in  1  system clock`; `reset_n  in  1  synchronous active-low reset`. Both belong to the single clock domain `clk`.
REQ-004 SHALL have port `select  in  1  bus access request, held by master until ready`.
REQ-005 SHALL have port `wstrb  in  4  byte write strobes; 0 = read`.
REQ-006 SHALL have port `addr  in  5  byte offset within the 32-byte window`.
REQ-007 SHALL have port `data_i  in  32  write data`.
REQ-008 SHALL have port `ready  out  1  transaction-complete pulse`.
REQ-009 SHALL have port `data_o  out  32  read data, valid while ready=1`.
REQ-010 SHALL have ports `rx_data  in  8  byte from UART receiver`; `rx_valid  in  1  one-cycle strobe qualifying rx_data`.
REQ-011 SHALL have port `irq  out  1  level interrupt: enabled and level >= THRESHOLD`.

Function
REQ-012 Register map SHALL be:
- 0x00 CTRL: bit0 enable (RW); bit1 flush (write-1, self-clearing, reads 0).
- 0x04 STATUS (RO except bit2): bit0 empty; bit1 full; bit2 overrun (sticky, write-1-to-clear); bits[16:8] level.
- 0x08 DATA (RO): bits[7:0] head byte; a read pops.
- 0x0C THRESHOLD (RW): bits[8:0].
- Other offsets: read 0, writes ignored.
REQ-013 Access SHALL start on a cycle with select=1, ready=0 and armed=1; ready=1 on the next cycle for exactly one cycle; armed SHALL clear at start and set only after a cycle with select=0, so a held select yields one access.
REQ-014 Writes SHALL take effect in the ready cycle; only bytes with wstrb[i]=1 update; wstrb=0 SHALL be a read.
REQ-015 data_o SHALL be 0 whenever ready=0.
REQ-016 While enable=1, rx_valid=1 SHALL push rx_data at that edge; while enable=0, rx_valid SHALL be ignored.
REQ-017 Push when full (without simultaneous pop) SHALL drop the byte and set overrun; contents unchanged.
REQ-018 DATA read when empty SHALL return 0, leave pointers unchanged, and not set any flag.
REQ-019 Simultaneous push and pop SHALL leave level unchanged; this also holds when full.
REQ-020 Flush SHALL zero pointers and level in the ready cycle and SHALL win over a same-cycle push; overrun is unaffected.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; level SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-022 irq SHALL be registered: irq = enable & (THRESHOLD != 0) & (level >= THRESHOLD), one cycle after level changes.

Reset
REQ-023 With reset_n=0 at a clk edge, the following SHALL hold:
- ready=0, data_o=0, irq=0, armed=1.
- enable=0, overrun=0, pointers=0, level=0.
- THRESHOLD=THR_RESET.
- RAM contents undefined.
REQ-024 Reset mid-transaction SHALL abort it with no ready pulse; a push in the reset cycle SHALL be lost.

Structure
REQ-025 Register offsets and STATUS/CTRL bit positions SHALL live in the shared peripheral include/package used by the uart and bus decoder.
REQ-026 Storage SHALL be a sub-module sync_fifo (parameter DEPTH, WIDTH=8) providing push, pop, flush, full, empty, level and head data; uart_rx_fifo adds bus, CTRL/STATUS and irq logic.

Verification
REQ-027 Write CTRL=1, pulse rx_valid with 0x61 then 0x65; read DATA twice -> 0x61, 0x65; then STATUS.empty=1.
REQ-028 Enable, push 17 bytes into DEPTH=16 -> STATUS = full=1, overrun=1, level=16. Write STATUS bit2=1 -> overrun=0.
REQ-029 THRESHOLD=3, push 3 bytes -> irq=1 one cycle after third push; one DATA read -> irq=0.
REQ-030 Hold select high for 10 cycles on a DATA read -> exactly one ready pulse and one pop.
REQ-031 Push 0x41 in the same cycle as the flush write -> level=0, empty=1.
REQ-032 DATA read on empty -> data_o=0 on ready; level stays 0. Read 0x14 -> 0.
